// File: rtl/wmem_seq_pkg.sv
// Shared definitions for the weight-memory sequencer.
// Provides the default width constants and the sequencer state encoding.
package wmem_seq_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ROW_NUM    = 6;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned PASS_WIDTH = 8;

  // Sequencer states
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

endpackage

// File: rtl/wmem_seq_rdptr.sv
// RUN-mode read pointer for the weight memory.
// Tracks the presented row r, the pass count p and the valid flag v, and
// produces the combinational read address plus last/done indications.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_run          sequencer is in RUN (counters held at 0 otherwise)
//   i_pe_ready     PE array accepts the presented row
//   i_rows         row count N (ADDR_WIDTH+1 bits)
//   i_passes       pass count P
//   o_rd_addr      memory read address for the next cycle's data
//   o_wgt_valid    memory read data is a valid row this cycle
//   o_wgt_last     presented row is row N-1
//   o_run_done     final row of the final pass is transferring this cycle
module wmem_seq_rdptr #(
  parameter int unsigned ADDR_WIDTH = wmem_seq_pkg::ADDR_WIDTH,
  parameter int unsigned PASS_WIDTH = wmem_seq_pkg::PASS_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_run,
  input  logic                  i_pe_ready,
  input  logic [ADDR_WIDTH:0]   i_rows,
  input  logic [PASS_WIDTH-1:0] i_passes,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_wgt_valid,
  output logic                  o_wgt_last,
  output logic                  o_run_done
);

  logic [ADDR_WIDTH:0]   r_q, r_d;
  logic [PASS_WIDTH-1:0] p_q, p_d;
  logic                  v_q, v_d;
  logic                  fire, row_last, pass_last;

  assign fire      = v_q & i_pe_ready;
  assign row_last  = (r_q == i_rows - (ADDR_WIDTH + 1)'(1));
  assign pass_last = (p_q == i_passes - PASS_WIDTH'(1));

  always_comb begin
    r_d = r_q;
    p_d = p_q;
    v_d = v_q;
    if (!i_run) begin
      r_d = '0;
      p_d = '0;
      v_d = 1'b0;
    end else if (!v_q) begin
      // Entry cycle: address 0 is being read, data appears next cycle.
      v_d = 1'b1;
    end else if (fire) begin
      if (row_last) begin
        r_d = '0;
        if (pass_last) v_d = 1'b0;
        else           p_d = p_q + PASS_WIDTH'(1);
      end else begin
        r_d = r_q + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  // Reading the next-state row keeps the address held under stall and
  // advances it in the same cycle as a transfer, so there are no bubbles.
  assign o_rd_addr   = r_d[ADDR_WIDTH-1:0];
  assign o_wgt_valid = v_q;
  assign o_wgt_last  = v_q & row_last;
  assign o_run_done  = fire & row_last & pass_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
      p_q <= '0;
      v_q <= 1'b0;
    end else begin
      r_q <= r_d;
      p_q <= p_d;
      v_q <= v_d;
    end
  end

endmodule

// File: rtl/wmem_seq.sv
// Weight-memory sequencer: loads host rows into the weight memory (LOAD) and
// replays rows 0..N-1 for P passes to the PE array (RUN).
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_ld_start, i_run_start      start pulses, accepted in IDLE only
//   i_rows, i_passes             N and P, sampled on an accepted start
//   i_ld_valid, i_ld_data        host row stream; o_ld_ready handshake
//   o_wr_en, o_wr_addr, o_wr_data memory write port
//   o_rd_addr                    memory read address (combinational)
//   i_pe_ready                   PE array accepts the presented row
//   o_wgt_valid, o_wgt_last      presented-row qualifiers
//   o_busy, o_done               status; o_done is a one-cycle pulse
module wmem_seq #(
  parameter int unsigned DATA_WIDTH    = wmem_seq_pkg::DATA_WIDTH,
  parameter int unsigned ROW_NUM       = wmem_seq_pkg::ROW_NUM,
  parameter int unsigned ADDR_WIDTH    = wmem_seq_pkg::ADDR_WIDTH,
  parameter int unsigned ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM,
  parameter int unsigned PASS_WIDTH    = wmem_seq_pkg::PASS_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ld_start,
  input  logic                     i_run_start,
  input  logic [ADDR_WIDTH:0]      i_rows,
  input  logic [PASS_WIDTH-1:0]    i_passes,
  input  logic                     i_ld_valid,
  input  logic [ROW_WGT_WIDTH-1:0] i_ld_data,
  output logic                     o_ld_ready,
  output logic                     o_wr_en,
  output logic [ADDR_WIDTH-1:0]    o_wr_addr,
  output logic [ROW_WGT_WIDTH-1:0] o_wr_data,
  output logic [ADDR_WIDTH-1:0]    o_rd_addr,
  input  logic                     i_pe_ready,
  output logic                     o_wgt_valid,
  output logic                     o_wgt_last,
  output logic                     o_busy,
  output logic                     o_done
);

  import wmem_seq_pkg::*;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   rows_q, rows_d;
  logic [ADDR_WIDTH:0]   ld_cnt_q, ld_cnt_d;
  logic [PASS_WIDTH-1:0] passes_q, passes_d;
  logic                  done_q, done_d;
  logic                  ld_fire, run_done;

  // Ready is masked by reset so the reset cycle can never write the memory.
  assign o_ld_ready = (state_q == StLoad) & ~i_rst;
  assign ld_fire    = i_ld_valid & o_ld_ready;
  assign o_wr_en    = ld_fire;
  assign o_wr_addr  = ld_cnt_q[ADDR_WIDTH-1:0];
  assign o_wr_data  = i_ld_data;
  assign o_busy     = (state_q != StIdle);
  assign o_done     = done_q;

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    passes_d = passes_q;
    ld_cnt_d = ld_cnt_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_ld_start) begin
          rows_d   = i_rows;
          ld_cnt_d = '0;
          if (i_rows == '0) done_d  = 1'b1;
          else              state_d = StLoad;
        end else if (i_run_start) begin
          rows_d   = i_rows;
          passes_d = i_passes;
          if (i_rows == '0 || i_passes == '0) done_d  = 1'b1;
          else                                state_d = StRun;
        end
      end
      StLoad: begin
        if (ld_fire) begin
          ld_cnt_d = ld_cnt_q + (ADDR_WIDTH + 1)'(1);
          if (ld_cnt_q == rows_q - (ADDR_WIDTH + 1)'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StRun: begin
        if (run_done) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      rows_q   <= '0;
      passes_q <= '0;
      ld_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      passes_q <= passes_d;
      ld_cnt_q <= ld_cnt_d;
      done_q   <= done_d;
    end
  end

  wmem_seq_rdptr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PASS_WIDTH (PASS_WIDTH)
  ) u_rdptr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_run       (state_q == StRun),
    .i_pe_ready  (i_pe_ready),
    .i_rows      (rows_q),
    .i_passes    (passes_q),
    .o_rd_addr   (o_rd_addr),
    .o_wgt_valid (o_wgt_valid),
    .o_wgt_last  (o_wgt_last),
    .o_run_done  (run_done)
  );

endmodule
